rtc_bus_arbiter: RTL
====================

RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

Interface
REQ-001 SHALL have clk, input, 1: rising-edge clock.
REQ-002 SHALL have reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have req_ini, input, 1: init-sequencer transaction request, held until ack_ini.
REQ-004 SHALL have addr_ini/data_ini, input, 8 each: init write address/data.
REQ-005 SHALL have init_done, input, 1: initialization complete; low means only req_ini is granted.
REQ-006 SHALL have req_wr, addr_wr, data_wr, input, 1/8/8: user write request, address and data.
REQ-007 SHALL have req_rd, addr_rd, input, 1/8: periodic read request and address.
REQ-008 SHALL have bus_busy, input, 1: bus-cycle engine busy; high for the duration of one transaction.
REQ-009 SHALL have bus_rdata, input, 8: engine read data, valid when bus_busy falls.
REQ-010 SHALL have bus_start, bus_we, bus_addr, bus_wdata, output, 1/1/8/8: transaction launch to engine.
REQ-011 SHALL have ack_ini, ack_wr, ack_rd, output, 1 each: one-cycle completion pulses.
REQ-012 SHALL have rd_data, output, 8: last completed read data.
REQ-013 SHALL have err, output, 1: one-cycle abort pulse (timeout build only).

Function
REQ-014 SHALL implement FSM states IDLE, LAUNCH, WAIT_BSY, WAIT_DONE, ACK.
REQ-015 IDLE: if any eligible request is pending, SHALL latch winner ID, bus_addr, bus_wdata and bus_we, then go to LAUNCH; otherwise stay in IDLE.
REQ-016 Priority SHALL be: req_ini first. Between req_wr and req_rd, round-robin applies: a pointer toggles to the other requester after each granted wr/rd. The pointer resets to favor wr.
REQ-017 While init_done=0, req_wr and req_rd SHALL be ignored and stay pending. While init_done=1, req_ini SHALL still be granted if asserted.
REQ-018 bus_we SHALL be 1 for ini/wr and 0 for rd. bus_wdata SHALL be 8'h00 for rd.
REQ-019 LAUNCH: bus_start SHALL be high for exactly this one cycle, then go to WAIT_BSY.
REQ-020 WAIT_BSY: SHALL wait for bus_busy=1, then go to WAIT_DONE. If bus_busy is already 1 on entry, SHALL advance on the next cycle.
REQ-021 WAIT_DONE: on bus_busy=0, SHALL go to ACK. For a rd grant, SHALL capture bus_rdata into rd_data in that same transition.
REQ-022 ACK: SHALL pulse the winner's ack_* for one cycle, then return to IDLE. A new grant SHALL not occur earlier than the cycle after ACK, so the minimum transaction is 5 cycles plus busy time.
REQ-023 bus_addr, bus_wdata and bus_we SHALL hold stable from LAUNCH through ACK.
REQ-024 A requester deasserting mid-transaction SHALL not abort the transaction; ack SHALL still pulse.
REQ-025 Simultaneous req_wr and req_rd SHALL be resolved by the round-robin pointer only.
REQ-026 Illegal state encodings SHALL return to IDLE on the next clock.

Reset
REQ-027 On reset, state SHALL be IDLE.
REQ-028 On reset, bus_start, bus_we, all ack_* and err SHALL be 0; bus_addr, bus_wdata and rd_data SHALL be 8'h00.
REQ-029 On reset, the round-robin pointer SHALL be wr and the timeout counter SHALL be 0.
REQ-030 Reset mid-transaction SHALL drop the transaction without an ack pulse.

Configuration
REQ-031 Macro RTC_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on LAUNCH and count in WAIT_BSY and WAIT_DONE. On reaching 8'hFF, the FSM SHALL go to ACK, pulse err together with the winner's ack, and leave rd_data unchanged.
REQ-032 RTC_ARB_TIMEOUT_EN undefined: no counter SHALL exist, err SHALL be constant 0, and the FSM SHALL wait indefinitely.

Verification
REQ-033 init_done=0, req_ini (addr 8'h02, data 8'h10) and req_wr together -> only ini is launched: bus_addr=8'h02, bus_wdata=8'h10, bus_we=1; ack_ini pulses once; wr stays pending.
REQ-034 init_done=1, req_wr and req_rd held continuously -> grants alternate wr, rd, wr, rd with no back-to-back repeats.
REQ-035 rd of 8'h21 with engine returning 8'h59 when busy falls -> rd_data=8'h59 and ack_rd pulses one cycle after busy falls.
REQ-036 Reset asserted during WAIT_DONE -> all outputs return to reset values immediately; no ack pulse.
REQ-037 RTC_ARB_TIMEOUT_EN defined, bus_busy stuck 0 after launch -> err and ack_wr pulse together 256 cycles after bus_start; FSM returns to IDLE.
REQ-038 bus_busy already high at LAUNCH -> WAIT_BSY lasts one cycle; transaction completes normally.

Source files
------------

// File: rtl/rtc_bus_arbiter.sv
// Three-way bus arbiter (init / write / read) feeding a single RTC bus-cycle engine.
// Optional abort on a stuck engine: define RTC_ARB_TIMEOUT_EN.
module rtc_bus_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_ini,
   input  logic [7:0] addr_ini,
   input  logic [7:0] data_ini,
   input  logic       init_done,
   input  logic       req_wr,
   input  logic [7:0] addr_wr,
   input  logic [7:0] data_wr,
   input  logic       req_rd,
   input  logic [7:0] addr_rd,
   input  logic       bus_busy,
   input  logic [7:0] bus_rdata,
   output logic       bus_start,
   output logic       bus_we,
   output logic [7:0] bus_addr,
   output logic [7:0] bus_wdata,
   output logic       ack_ini,
   output logic       ack_wr,
   output logic       ack_rd,
   output logic [7:0] rd_data,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_BSY  = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_ACK       = 3'd4
   } state_t;

   typedef enum logic [1:0] {G_INI = 2'd0, G_WR = 2'd1, G_RD = 2'd2} gnt_t;

   state_t     r_state, w_next;
   gnt_t       r_gnt, w_gnt;
   logic       w_grant;
   logic       w_timeout;
   logic       r_rr_rd;      // 1: rd wins a wr/rd tie
   logic       r_bus_we;
   logic [7:0] r_bus_addr, r_bus_wdata, r_rd_data;

   // Init requests always win; wr/rd are only eligible once init is done.
   always_comb begin
      w_grant = 1'b0;
      w_gnt   = G_INI;
      if (req_ini) begin
         w_grant = 1'b1;
         w_gnt   = G_INI;
      end else if (init_done) begin
         if (req_wr && (!req_rd || !r_rr_rd)) begin
            w_grant = 1'b1;
            w_gnt   = G_WR;
         end else if (req_rd) begin
            w_grant = 1'b1;
            w_gnt   = G_RD;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      bus_start = 1'b0;
      ack_ini   = 1'b0;
      ack_wr    = 1'b0;
      ack_rd    = 1'b0;
      case (r_state)
         S_IDLE:      if (w_grant) w_next = S_LAUNCH;
         S_LAUNCH: begin
            bus_start = 1'b1;
            w_next    = S_WAIT_BSY;
         end
         S_WAIT_BSY: begin
            if (w_timeout)     w_next = S_ACK;
            else if (bus_busy) w_next = S_WAIT_DONE;
         end
         // A completed transfer takes precedence over a coincident timeout.
         S_WAIT_DONE: begin
            if (!bus_busy)      w_next = S_ACK;
            else if (w_timeout) w_next = S_ACK;
         end
         S_ACK: begin
            ack_ini = (r_gnt == G_INI);
            ack_wr  = (r_gnt == G_WR);
            ack_rd  = (r_gnt == G_RD);
            w_next  = S_IDLE;
         end
         default:     w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_gnt       <= G_INI;
         r_rr_rd     <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= 8'h00;
         r_bus_wdata <= 8'h00;
      end else if (r_state == S_IDLE && w_grant) begin
         r_gnt <= w_gnt;
         case (w_gnt)
            G_INI: begin
               r_bus_we    <= 1'b1;
               r_bus_addr  <= addr_ini;
               r_bus_wdata <= data_ini;
            end
            G_WR: begin
               r_bus_we    <= 1'b1;
               r_bus_addr  <= addr_wr;
               r_bus_wdata <= data_wr;
               r_rr_rd     <= 1'b1;
            end
            default: begin
               r_bus_we    <= 1'b0;
               r_bus_addr  <= addr_rd;
               r_bus_wdata <= 8'h00;
               r_rr_rd     <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_rd_data <= 8'h00;
      else if (r_state == S_WAIT_DONE && !bus_busy && r_gnt == G_RD)
         r_rd_data <= bus_rdata;
   end

`ifdef RTC_ARB_TIMEOUT_EN
   logic [7:0] r_to_cnt;
   logic       r_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_to_cnt <= 8'h00;
      else if (r_state == S_LAUNCH)
         r_to_cnt <= 8'h00;
      else if (r_state == S_WAIT_BSY || r_state == S_WAIT_DONE)
         r_to_cnt <= r_to_cnt + 8'h01;
   end

   // Fires on the edge where the counter reaches FF, landing ACK 256 cycles after launch.
   assign w_timeout = (r_to_cnt == 8'hFE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_err <= 1'b0;
      else       r_err <= w_timeout &&
                          (r_state == S_WAIT_BSY || (r_state == S_WAIT_DONE && bus_busy));
   end

   assign err = r_err && (r_state == S_ACK);
`else
   assign w_timeout = 1'b0;
   assign err       = 1'b0;
`endif

   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;
   assign rd_data   = r_rd_data;

endmodule
